// File: rtl/clk_div_pkg.sv
// Shared sizing for the power-of-two clock divider chain.
// Stage count fixes both the number of toggle flops and the counter width.
// No flow control: constants only.
package clk_div_pkg;

    localparam int NUM_STAGES = 4;
    localparam int CNT_W      = NUM_STAGES;

endpackage

// File: rtl/div2_stage.sv
// One divide-by-2 stage: a toggle flop plus the AND carry to the next stage.
// Latency: q updates on the rising clk edge after toggle_en is sampled high.
// No backpressure: free-running, synchronous active-high reset.
module div2_stage (
    input  logic clk,
    input  logic rst,
    input  logic toggle_en,
    output logic q,
    output logic carry_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (toggle_en) begin
            q <= ~q;
        end
    end

    // Next stage toggles only when this stage and all below it are about to wrap.
    assign carry_out = toggle_en & q;

endmodule

// File: rtl/divide_by_2_to_the_n.sv
// Four-stage synchronous binary counter exporting clk/2, clk/4, clk/8, clk/16.
// Latency: one clk edge from reset or count step to outputs; outputs are flop Q pins.
// No backpressure: counts every edge unless rst is sampled high.
module divide_by_2_to_the_n
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic divBy2,
    output logic divBy4,
    output logic divBy8,
    output logic divBy16
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] toggleEn;
    logic [CNT_W-1:0] carry;
    logic             unusedTermCarry;

    // Every flop runs on clk; only the toggle enable ripples, never the clock.
    assign toggleEn[0] = 1'b1;

    for (genvar k = 0; k < CNT_W; k++) begin : gStage
        div2_stage uStage (
            .clk       (clk),
            .rst       (rst),
            .toggle_en (toggleEn[k]),
            .q         (cnt[k]),
            .carry_out (carry[k])
        );
        if (k < CNT_W - 1) begin : gChain
            assign toggleEn[k+1] = carry[k];
        end
    end

    assign unusedTermCarry = carry[CNT_W-1];

    assign divBy2  = cnt[0];
    assign divBy4  = cnt[1];
    assign divBy8  = cnt[2];
    assign divBy16 = cnt[3];

endmodule

// File: tb/tb_divide_by_2_to_the_n.sv
// Directed bench for the four-stage clock divider: vector table plus corner sequences.
module tb_divide_by_2_to_the_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic divBy2, divBy4, divBy8, divBy16;

    int total = 0;
    int bad   = 0;

    divide_by_2_to_the_n dut (
        .clk     (clk),
        .rst     (rst),
        .divBy2  (divBy2),
        .divBy4  (divBy4),
        .divBy8  (divBy8),
        .divBy16 (divBy16)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       rstIn;
        logic [3:0] expCnt;
    } vec_t;

    localparam int NVEC = 34;
    vec_t tbl[NVEC];

    // Rise-to-rise period of each output, measured from the outputs themselves.
    longint lastRise[4];
    longint period[4];
    always @(posedge divBy2)  begin period[0] = $time - lastRise[0]; lastRise[0] = $time; end
    always @(posedge divBy4)  begin period[1] = $time - lastRise[1]; lastRise[1] = $time; end
    always @(posedge divBy8)  begin period[2] = $time - lastRise[2]; lastRise[2] = $time; end
    always @(posedge divBy16) begin period[3] = $time - lastRise[3]; lastRise[3] = $time; end

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic checkPer(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Drive rst away from the edge, then sample just after the edge.
    task automatic step(input logic r, input logic [3:0] exp, input string name);
        @(negedge clk);
        rst = r;
        @(posedge clk);
        #1;
        check4(name, {divBy16, divBy8, divBy4, divBy2}, exp);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            lastRise[i] = 0;
            period[i]   = 0;
        end

        // Reset from unknown across two edges, then 32 free-running edges with wrap.
        tbl[0] = '{rstIn: 1'b1, expCnt: 4'd0};
        tbl[1] = '{rstIn: 1'b1, expCnt: 4'd0};
        for (int i = 0; i < 32; i++) begin
            logic [4:0] n;
            n = 5'(i + 1);
            tbl[2+i] = '{rstIn: 1'b0, expCnt: n[3:0]};
        end

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].rstIn, tbl[i].expCnt, $sformatf("vec%0d", i));
        end

        checkPer("periodDiv2",  period[0], 40);
        checkPer("periodDiv4",  period[1], 80);
        checkPer("periodDiv8",  period[2], 160);
        checkPer("periodDiv16", period[3], 320);

        // Counter is at 0; walk to 15 and confirm the simultaneous wrap.
        for (int i = 1; i < 16; i++) begin
            logic [4:0] n;
            n = 5'(i);
            step(1'b0, n[3:0], "runToMax");
        end
        step(1'b0, 4'b0000, "wrapAllFall");

        // Mid-count reset at 6.
        for (int i = 1; i <= 6; i++) begin
            logic [4:0] n;
            n = 5'(i);
            step(1'b0, n[3:0], "runToSix");
        end
        step(1'b1, 4'b0000, "midReset");
        step(1'b0, 4'b0001, "restartAfterMid");
        step(1'b0, 4'b0010, "restartTwo");

        // Held reset for four edges, then release gives divBy2 only.
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, "heldReset");
        step(1'b0, 4'b0001, "releaseAfterHeld");
        step(1'b0, 4'b0010, "afterHeldTwo");
        step(1'b0, 4'b0011, "afterHeldThree");

        // A short rst pulse that never spans a rising edge must be ignored.
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        check4("asyncPulseIgnored", {divBy16, divBy8, divBy4, divBy2}, 4'b0100);
        step(1'b0, 4'b0101, "asyncPulseNext");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
